// File: rtl/gpio_irq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// gpio_irq_ctrl_pkg
// Shared definitions for the GPIO input-capture / interrupt controller:
//   - APB register addresses (3-bit byte-register map)
//   - IRQ_TYPE bit encodings
//   - reset-blanking length helper
// Optional feature macro used by this slice: GPIO_IRQ_DEBOUNCE_EN
// -----------------------------------------------------------------------------
package gpio_irq_ctrl_pkg;

    localparam logic [2:0] GPIO_IRQ_ADDR_IN   = 3'd0;
    localparam logic [2:0] GPIO_IRQ_ADDR_EN   = 3'd1;
    localparam logic [2:0] GPIO_IRQ_ADDR_TYPE = 3'd2;
    localparam logic [2:0] GPIO_IRQ_ADDR_POL  = 3'd3;
    localparam logic [2:0] GPIO_IRQ_ADDR_BOTH = 3'd4;
    localparam logic [2:0] GPIO_IRQ_ADDR_STAT = 3'd5;
    localparam logic [2:0] GPIO_IRQ_ADDR_MSK  = 3'd6;

    // Per-pin IRQ_TYPE bit encoding.
    typedef enum logic {
        IRQ_TYPE_EDGE  = 1'b0,
        IRQ_TYPE_LEVEL = 1'b1
    } irq_type_e;

    // Edge events are suppressed for one cycle beyond the time the input path
    // needs to settle after reset, so pins held active through reset cannot
    // produce a spurious edge while the pipeline fills.
    function automatic int unsigned gpio_irq_blank_len(input int unsigned settle_cycles);
        return settle_cycles + 1;
    endfunction

endpackage

// File: rtl/gpio_in_cond.sv
// -----------------------------------------------------------------------------
// gpio_in_cond
// Single-pin input conditioning: SYNC_STAGES-deep synchronizer, optionally
// followed by a debouncer (GPIO_IRQ_DEBOUNCE_EN). The debouncer only lets the
// output follow the synchronizer once it has differed for DEB_CYCLES
// consecutive cycles; any reversion restarts the count.
//
// Ports:
//   clk_i   in  clock
//   rst_i   in  synchronous active-high reset
//   pad_i   in  raw pad value, asynchronous to clk_i
//   cond_o  out conditioned pin value
// Macro: GPIO_IRQ_DEBOUNCE_EN
// -----------------------------------------------------------------------------
module gpio_in_cond #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pad_i,
    output logic cond_o
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("gpio_in_cond: SYNC_STAGES must be at least 2");
    end
    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("gpio_in_cond: DEB_CYCLES must be at least 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef GPIO_IRQ_DEBOUNCE_EN
    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cond_q, cond_d;

    always_comb begin
        cnt_d  = '0;
        cond_d = cond_q;
        if (sync_out != cond_q) begin
            // This cycle completes DEB_CYCLES consecutive differing samples.
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                cond_d = sync_out;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            cond_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            cond_q <= cond_d;
        end
    end

    assign cond_o = cond_q;
`else
    assign cond_o = sync_out;
`endif

endmodule

// File: rtl/gpio_irq_ctrl.sv
// -----------------------------------------------------------------------------
// gpio_irq_ctrl
// Input-capture and interrupt controller for the 8 expander pads, exposed as
// an APB slave. Each pin is conditioned (synchronizer, optional debouncer),
// edge-detected against its previous conditioned value, and reported in a
// status register that feeds a single registered interrupt line.
//
// Register map (paddr[2:0]):
//   0 IN (RO)   1 IRQ_EN   2 IRQ_TYPE (1=level)   3 IRQ_POL (1=rise/high)
//   4 IRQ_BOTH  5 IRQ_STAT (edge bits W1C)  6 IRQ_MSK (RO, STAT&EN)  7 zero
//
// Ports:
//   pclk     in  APB clock
//   preset   in  synchronous active-high reset
//   paddr    in  register address
//   pselx    in  slave select
//   penable  in  access phase
//   pwrite   in  1 = write
//   pwdata   in  write data
//   pready   out always 1 (zero wait states)
//   prdata   out read data, valid during the access phase, else 0
//   y        in  raw pad inputs (asynchronous)
//   irq      out registered OR of STAT & EN
// Macro: GPIO_IRQ_DEBOUNCE_EN (adds per-pin debouncer of DEB_CYCLES)
// -----------------------------------------------------------------------------
module gpio_irq_ctrl
    import gpio_irq_ctrl_pkg::*;
#(
    parameter int unsigned PADDR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 4
) (
    input  logic                   pclk,
    input  logic                   preset,
    input  logic [PADDR_WIDTH-1:0] paddr,
    input  logic                   pselx,
    input  logic                   penable,
    input  logic                   pwrite,
    input  logic [DATA_WIDTH-1:0]  pwdata,
    output logic                   pready,
    output logic [DATA_WIDTH-1:0]  prdata,
    input  logic [7:0]             y,
    output logic                   irq
);

    if (DATA_WIDTH != 8) begin : g_bad_dw
        $error("gpio_irq_ctrl: DATA_WIDTH must be 8 (one bit per pin)");
    end
    if (PADDR_WIDTH < 3) begin : g_bad_aw
        $error("gpio_irq_ctrl: PADDR_WIDTH must be at least 3");
    end

`ifdef GPIO_IRQ_DEBOUNCE_EN
    localparam int unsigned SETTLE = SYNC_STAGES + DEB_CYCLES;
`else
    localparam int unsigned SETTLE = SYNC_STAGES;
`endif
    localparam int unsigned BLANK_LEN = gpio_irq_blank_len(SETTLE);
    localparam int unsigned BLANK_W   = $clog2(BLANK_LEN + 1);

    logic [7:0] cond;

    for (genvar i = 0; i < 8; i++) begin : g_pin
        gpio_in_cond #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CYCLES  (DEB_CYCLES)
        ) u_cond (
            .clk_i  (pclk),
            .rst_i  (preset),
            .pad_i  (y[i]),
            .cond_o (cond[i])
        );
    end

    logic [7:0]         en_q,   en_d;
    logic [7:0]         type_q, type_d;
    logic [7:0]         pol_q,  pol_d;
    logic [7:0]         both_q, both_d;
    logic [7:0]         stat_q, stat_d;
    logic [7:0]         prev_q;
    logic               irq_q,  irq_d;
    logic [BLANK_W-1:0] blank_q, blank_d;

    logic [2:0] addr;
    logic       access;
    logic       wr;
    logic       blanking;
    logic [7:0] w1c;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] evt;
    logic [7:0] level_hit;
    logic [7:0] rdata;

    assign addr     = paddr[2:0];
    assign access   = pselx & penable;
    assign wr       = access & pwrite;
    assign blanking = (blank_q < BLANK_W'(BLANK_LEN));

    always_comb begin
        en_d    = en_q;
        type_d  = type_q;
        pol_d   = pol_q;
        both_d  = both_q;
        stat_d  = stat_q;
        w1c     = '0;
        blank_d = blanking ? blank_q + 1'b1 : blank_q;

        if (wr) begin
            case (addr)
                GPIO_IRQ_ADDR_EN:   en_d   = pwdata;
                GPIO_IRQ_ADDR_TYPE: type_d = pwdata;
                GPIO_IRQ_ADDR_POL:  pol_d  = pwdata;
                GPIO_IRQ_ADDR_BOTH: both_d = pwdata;
                GPIO_IRQ_ADDR_STAT: w1c    = pwdata;
                default: ;
            endcase
        end

        // Events come only from the conditioned input moving, so rewriting
        // TYPE/POL/BOTH can never manufacture one.
        rise      = cond & ~prev_q;
        fall      = ~cond & prev_q;
        evt       = blanking ? '0
                  : (both_q & (rise | fall)) | (~both_q & ((pol_q & rise) | (~pol_q & fall)));
        level_hit = ~(cond ^ pol_q);

        for (int i = 0; i < 8; i++) begin
            if (type_q[i] == IRQ_TYPE_LEVEL) begin
                stat_d[i] = level_hit[i];
            end else begin
                // A new event wins over a simultaneous clear.
                stat_d[i] = evt[i] | (stat_q[i] & ~w1c[i]);
            end
        end

        irq_d = |(stat_q & en_q);
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            en_q    <= '0;
            type_q  <= '0;
            pol_q   <= '0;
            both_q  <= '0;
            stat_q  <= '0;
            prev_q  <= '0;
            irq_q   <= 1'b0;
            blank_q <= '0;
        end else begin
            en_q    <= en_d;
            type_q  <= type_d;
            pol_q   <= pol_d;
            both_q  <= both_d;
            stat_q  <= stat_d;
            prev_q  <= cond;
            irq_q   <= irq_d;
            blank_q <= blank_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (access && !preset) begin
            case (addr)
                GPIO_IRQ_ADDR_IN:   rdata = cond;
                GPIO_IRQ_ADDR_EN:   rdata = en_q;
                GPIO_IRQ_ADDR_TYPE: rdata = type_q;
                GPIO_IRQ_ADDR_POL:  rdata = pol_q;
                GPIO_IRQ_ADDR_BOTH: rdata = both_q;
                GPIO_IRQ_ADDR_STAT: rdata = stat_q;
                GPIO_IRQ_ADDR_MSK:  rdata = stat_q & en_q;
                default:            rdata = '0;
            endcase
        end
    end

    assign prdata = rdata;
    assign pready = 1'b1;
    assign irq    = irq_q;

endmodule
